// File: rtl/outport_fifo.sv
// Buffered CPU output port: strobed writes queued in a DEPTH-entry FIFO, drained via valid/ready.
// Define OUTPORT_FIFO_OVERWRITE_EN for drop-oldest on overflow; default is drop-newest.
module outport_fifo #(
  parameter int unsigned n     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [n-1:0]               wr_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [n-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  logic pop;
  logic push;
  logic rp_adv;
  logic ovf_set;
  logic cnt_inc;
  logic cnt_dec;

  assign empty    = (count == CW'(0));
  assign full     = (count == CW'(DEPTH));
  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem[rp];

  // Push/pop decode; a pop always frees a slot for a same-cycle write.
  always_comb begin
    pop = rd_valid & rd_ready;
`ifdef OUTPORT_FIFO_OVERWRITE_EN
    push    = wr_en;
    ovf_set = wr_en & full & ~pop;
    rp_adv  = pop | ovf_set;
`else
    push    = wr_en & (~full | pop);
    ovf_set = wr_en & full & ~pop;
    rp_adv  = pop;
`endif
    cnt_inc = push & ~pop & ~full;
    cnt_dec = pop & ~push;
  end

  // Storage is deliberately not reset; rd_data is gated while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)    wp <= wp + AW'(1);
      if (rp_adv)  rp <= rp + AW'(1);
      if (cnt_inc)      count <= count + CW'(1);
      else if (cnt_dec) count <= count - CW'(1);
      // A new loss in the same cycle as a clear keeps the flag set.
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_outport_fifo.sv
// Directed self-checking bench for outport_fifo (n=8, DEPTH=4).
module tb_outport_fifo;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_ovf;

  int passed = 0;
  int total  = 0;

  outport_fifo #(.n(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ovf_order [4];

  initial begin
`ifdef OUTPORT_FIFO_OVERWRITE_EN
    ovf_order = '{8'h22, 8'h33, 8'h44, 8'h55};
`else
    ovf_order = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_ready = 1'b0; clr_ovf = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'h00);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Fill 0x11..0x44
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h11 * (i + 1));
      cyc();
      if (i == 0) begin
        chk("lat_valid", 32'(rd_valid), 32'd1);
        chk("lat_data", 32'(rd_data), 32'h11);
      end
    end
    wr_en = 1'b0;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);

    // Overflow write
    wr_en = 1'b1; wr_data = 8'h55;
    cyc();
    wr_en = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_full", 32'(full), 32'd1);

    // Drain
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain1_%0d", i), 32'(rd_data), 32'(ovf_order[i]));
      cyc();
    end
    rd_ready = 1'b0;
    chk("drain1_empty", 32'(empty), 32'd1);
    chk("drain1_count", 32'(count), 32'd0);
    chk("drain1_data0", 32'(rd_data), 32'h00);
    chk("rdy_empty_noop_count", 32'(count), 32'd0);

    // Asynchronous reset between edges
    wr_en = 1'b1; wr_data = 8'h77;
    cyc();
    wr_en = 1'b0;
    chk("pre_arst_count", 32'(count), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_data", 32'(rd_data), 32'h00);
    chk("arst_ovf", 32'(overflow), 32'd0);
    #2 reset = 1'b0;
    cyc();

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h11 * (i + 1));
      cyc();
    end
    wr_en = 1'b1; wr_data = 8'h66; rd_ready = 1'b1;
    cyc();
    wr_en = 1'b0;
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_0", 32'(rd_data), 32'h22); cyc();
    chk("pp_1", 32'(rd_data), 32'h33); cyc();
    chk("pp_2", 32'(rd_data), 32'h44); cyc();
    chk("pp_3", 32'(rd_data), 32'h66); cyc();
    rd_ready = 1'b0;
    chk("pp_empty", 32'(empty), 32'd1);

    // Wrap-around: 10 push+pop cycles from count=1
    wr_en = 1'b1; wr_data = 8'hA0;
    cyc();
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(8'hA1 + i);
      chk($sformatf("wrap_%0d", i), 32'(rd_data), 32'(8'hA0 + i));
      cyc();
    end
    wr_en = 1'b0; rd_ready = 1'b0;
    chk("wrap_count", 32'(count), 32'd1);
    chk("wrap_head", 32'(rd_data), 32'hAA);

    // Fill, then overflow together with clr_ovf
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hAB + i);
      cyc();
    end
    chk("clr_full", 32'(full), 32'd1);
    wr_en = 1'b1; wr_data = 8'hEE; clr_ovf = 1'b1;
    cyc();
    wr_en = 1'b0;
    chk("clr_set_wins", 32'(overflow), 32'd1);
    chk("clr_set_count", 32'(count), 32'd4);
    cyc();
    clr_ovf = 1'b0;
    chk("clr_alone", 32'(overflow), 32'd0);
`ifdef OUTPORT_FIFO_OVERWRITE_EN
    chk("clr_head", 32'(rd_data), 32'hAB);
`else
    chk("clr_head", 32'(rd_data), 32'hAA);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
